vga_timing_gen: RTL

Parametrised VGA raster timing generator with an internal pixel-clock-enable divider. It produces sync pulses with configurable polarity, active-video gating, pixel coordinates, and line/frame start strobes. All outputs are mutually aligned. It sits between the system clock and the pixel/colour pipeline, and generalises the fixed 640x480 sync generator to any mode that fits the counter width.

---
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. An internal divider turns clk
//   into a one-clk-wide pixel enable; on each enable the raster position
//   advances (active, front porch, sync, back porch) and every decoded output
//   is registered from the new position, so all outputs stay mutually aligned.
//
//   Optional feature: define VGA_FRAME_CNT_EN to add an 8-bit frame_count
//   output that counts end-of-frame wraps.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   p_tick       out  pixel enable (constant 1 when CLK_DIV = 1)
//   hsync        out  horizontal sync, active level H_POL
//   vsync        out  vertical sync, active level V_POL
//   video_on     out  high while the position is inside the active area
//   pixel_x      out  current column  [CW-1:0]
//   pixel_y      out  current line    [CW-1:0]
//   line_start   out  one-clk pulse when x loads 0
//   frame_start  out  one-clk pulse when (0,0) loads
//   frame_count  out  [7:0] frame wrap counter (VGA_FRAME_CNT_EN only)
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (CLK_DIV < 1 || (1 << CW) < H_TOTAL || (1 << CW) < V_TOTAL) begin : g_param_check
    $error("vga_timing_gen: CLK_DIV must be >= 1 and 2^CW must cover H_TOTAL and V_TOTAL");
  end

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_LO = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_LO = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_HI = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          H_LVL     = (H_POL != 0);
  localparam logic          V_LVL     = (V_POL != 0);

  // Pixel enable divider
  if (CLK_DIV == 1) begin : g_nodiv
    assign p_tick = 1'b1;
  end else begin : g_div
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                    div_cnt <= '0;
      else if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                        div_cnt <= div_cnt + DW'(1);
    end

    assign p_tick = (div_cnt == DIV_LAST);
  end

  logic          started;
  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;

  // pixel_x/pixel_y double as the raster counters; the first enable after
  // reset only loads (0,0) so the origin is presented for a full pixel.
  always_comb begin
    next_x = '0;
    next_y = '0;
    if (started) begin
      next_y = pixel_y;
      if (pixel_x == H_LAST) begin
        next_x = '0;
        if (pixel_y == V_LAST) next_y = '0;
        else                   next_y = pixel_y + CW'(1);
      end else begin
        next_x = pixel_x + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started     <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= ~H_LVL;
      vsync       <= ~V_LVL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (p_tick) begin
        started     <= 1'b1;
        pixel_x     <= next_x;
        pixel_y     <= next_y;
        video_on    <= (next_x < H_ACT) && (next_y < V_ACT);
        hsync       <= (next_x >= H_SYNC_LO && next_x <= H_SYNC_HI) ? H_LVL : ~H_LVL;
        vsync       <= (next_y >= V_SYNC_LO && next_y <= V_SYNC_HI) ? V_LVL : ~V_LVL;
        line_start  <= (next_x == '0);
        frame_start <= (next_x == '0) && (next_y == '0);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts real end-of-frame wraps only; the initial (0,0) load is excluded.
  logic frame_wrap;
  assign frame_wrap = started && (pixel_x == H_LAST) && (pixel_y == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       frame_count <= '0;
    else if (p_tick && frame_wrap) frame_count <= frame_count + 8'd1;
  end
`endif

endmodule
